// File: rtl/divisor_frecuencia_prog_if.sv
// Control/status bundle for the programmable frequency divider: settings load
// handshake on one side, divided output and status flags on the other.
interface divisor_frecuencia_prog_if #(
  parameter int WIDTH = 28
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] per_in;
  logic [WIDTH-1:0] duty_in;
  logic [1:0]       mode_in;
  logic             salida;
  logic             tick;
  logic             busy;
  logic             load_ack;

  modport master (
    output enable, load, per_in, duty_in, mode_in,
    input  salida, tick, busy, load_ack
  );

  modport slave (
    input  enable, load, per_in, duty_in, mode_in,
    output salida, tick, busy, load_ack
  );
endinterface

// File: rtl/divisor_frecuencia_prog.sv
// Runtime-programmable clock divider (TOGGLE / PULSE / PWM). New settings wait in
// shadow registers and are applied only at a period boundary, or at once while disabled.
module divisor_frecuencia_prog #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 100000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  divisor_frecuencia_prog_if.slave bus
);
  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] per_reg, duty_reg;
  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] sh_per_reg, sh_duty_reg;
  logic [1:0]       sh_mode_reg;
  logic             salida_reg, salida_next;
  logic             tick_reg, busy_reg, load_ack_reg;

  logic [WIDTH-1:0] pe, last, duty_eff;
  logic [1:0]       mode_eff;
  logic             boundary, apply, old_toggle;

  always_comb begin
    pe         = (per_reg < WIDTH'(2)) ? WIDTH'(2) : per_reg;
    last       = pe - WIDTH'(1);
    // >= keeps the counter bounded even if a disabled-time apply shrank the period
    boundary   = bus.enable && (cnt_reg >= last);
    apply      = busy_reg && (boundary || !bus.enable);

    cnt_next = cnt_reg;
    if (boundary) begin
      cnt_next = '0;
    end else if (bus.enable) begin
      cnt_next = cnt_reg + WIDTH'(1);
    end

    mode_eff   = apply ? sh_mode_reg : mode_reg;
    duty_eff   = apply ? sh_duty_reg : duty_reg;
    old_toggle = (mode_reg != MODE_PULSE) && (mode_reg != MODE_PWM);

    // A mode switch into TOGGLE keeps the level; staying in TOGGLE keeps toggling
    salida_next = salida_reg;
    case (mode_eff)
      MODE_PULSE: salida_next = boundary;
      MODE_PWM:   salida_next = (cnt_next < duty_eff);
      default:    salida_next = (boundary && old_toggle) ? ~salida_reg : salida_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      per_reg      <= WIDTH'(DEFAULT_DIV);
      duty_reg     <= WIDTH'(DEFAULT_DIV / 2);
      mode_reg     <= MODE_TOGGLE;
      salida_reg   <= 1'b0;
      tick_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      load_ack_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      salida_reg   <= salida_next;
      tick_reg     <= boundary;
      load_ack_reg <= apply;
      busy_reg     <= apply ? bus.load : (busy_reg | bus.load);
      if (apply) begin
        per_reg  <= sh_per_reg;
        duty_reg <= sh_duty_reg;
        mode_reg <= sh_mode_reg;
      end
    end
  end

  // Shadow contents are meaningless until busy is set, so they need no reset
  always_ff @(posedge clock) begin
    if (bus.load) begin
      sh_per_reg  <= bus.per_in;
      sh_duty_reg <= bus.duty_in;
      sh_mode_reg <= bus.mode_in;
    end
  end

  assign bus.salida   = salida_reg;
  assign bus.tick     = tick_reg;
  assign bus.busy     = busy_reg;
  assign bus.load_ack = load_ack_reg;
endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Scenario bench for divisor_frecuencia_prog (WIDTH=8, DEFAULT_DIV=4); each cycle's
// expected {salida,tick,busy,load_ack} is queued when driven and popped after the edge.
module tb_divisor_frecuencia_prog;
  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];

  divisor_frecuencia_prog_if #(.WIDTH(8)) bus ();

  divisor_frecuencia_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] outs();
    return {bus.salida, bus.tick, bus.busy, bus.load_ack};
  endfunction

  task automatic drive(input logic en, input logic ld, input int per, input int duty, input int mode);
    bus.enable  = en;
    bus.load    = ld;
    bus.per_in  = 8'(per);
    bus.duty_in = 8'(duty);
    bus.mode_in = 2'(mode);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] want, got;
    logic t;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 0);
    @(posedge clock);
    #1;
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got=%b expected=0000", outs());
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      t = (k % 4 == 0);
      exp_q.push_back({1'((k / 4) % 2), t, 1'b0, 1'b0});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL default_toggle cycle=%0d got=%b expected=%b", k, got, want);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_pulse();
    logic [3:0] want, got;
    logic t;
    do_reset();
    for (int j = 1; j <= 19; j++) begin
      drive(1'b1, j == 1, 5, 2, 1);
      t = (j == 4) || (j > 4 && (j - 4) % 5 == 0);
      exp_q.push_back({(j >= 4) ? t : 1'b0, t, j <= 3, j == 4});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pulse_mode cycle=%0d got=%b expected=%b", j, got, want);
      end
    end
    $display("test_pulse done");
  endtask

  task automatic test_pwm();
    logic [3:0] want, got;
    logic s, t, b, a;
    int c, dact, dload;
    do_reset();
    for (int j = 1; j <= 44; j++) begin
      dload = (j == 1) ? 3 : (j == 15) ? 0 : 12;
      drive(1'b1, (j == 1) || (j == 15) || (j == 25), 10, dload, 2);
      dact = (j < 24) ? 3 : (j < 34) ? 0 : 12;
      if (j < 4) begin
        s = 1'b0;
        t = 1'b0;
      end else begin
        c = (j - 4) % 10;
        t = (c == 0);
        s = (c < dact);
      end
      b = (j <= 3) || (j >= 15 && j <= 23) || (j >= 25 && j <= 33);
      a = (j == 4) || (j == 24) || (j == 34);
      exp_q.push_back({s, t, b, a});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pwm_mode cycle=%0d got=%b expected=%b", j, got, want);
      end
    end
    $display("test_pwm done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] want, got;
    logic t;
    int nt;
    do_reset();
    for (int j = 1; j <= 25; j++) begin
      drive(1'b1, (j == 2) || (j == 3), (j == 2) ? 6 : 7, 0, 0);
      t = (j == 4) || (j > 4 && (j - 4) % 7 == 0);
      nt = (j < 4) ? 0 : 1 + (j - 4) / 7;
      exp_q.push_back({1'(nt % 2), t, (j == 2) || (j == 3), j == 4});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d got=%b expected=%b", j, got, want);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_disable();
    logic [3:0] want, got;
    logic t;
    int nt;
    do_reset();
    for (int j = 1; j <= 20; j++) begin
      drive(!(j >= 3 && j <= 12), j == 8, 3, 0, 0);
      t = (j == 13) || (j == 16) || (j == 19);
      nt = (j < 13) ? 0 : 1 + (j - 13) / 3;
      exp_q.push_back({1'(nt % 2), t, j == 8, j == 9});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL disable_freeze cycle=%0d got=%b expected=%b", j, got, want);
      end
    end
    $display("test_disable done");
  endtask

  task automatic test_clamp_and_async_reset();
    logic [3:0] want, got;
    logic t;
    int nt, per;
    do_reset();
    for (int j = 1; j <= 17; j++) begin
      per = (j == 1) ? 0 : (j == 11) ? 1 : 9;
      drive(1'b1, (j == 1) || (j == 11) || (j == 17), per, 0, 0);
      t = (j >= 4) && (j <= 16) && (j % 2 == 0);
      nt = (j < 4) ? 0 : ((((j > 16) ? 16 : j) - 4) / 2 + 1);
      exp_q.push_back({1'(nt % 2), t, (j <= 3) || (j == 11) || (j == 17), (j == 4) || (j == 12)});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clamp_period cycle=%0d got=%b expected=%b", j, got, want);
      end
    end
    drive(1'b1, 1'b0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b expected=0000", outs());
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      t = (k % 4 == 0);
      exp_q.push_back({1'((k / 4) % 2), t, 1'b0, 1'b0});
      @(posedge clock);
      #1;
      got = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset_default cycle=%0d got=%b expected=%b", k, got, want);
      end
    end
    $display("test_clamp_and_async_reset done");
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    test_reset();
    test_pulse();
    test_pwm();
    test_back_to_back();
    test_disable();
    test_clamp_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
